// File: rtl/spin_phase_deserializer_pkg.sv
// Shared sizes, types and fill-state encoding for the spin phase deserializer.
package spin_phase_deserializer_pkg;

    localparam int NUM_SPINS             = 64;
    localparam int NUM_SPINS_EXP         = 6;
    localparam int NL_OUT_PHASE_BITWIDTH = 8;
    localparam int ERR_CNT_W             = 8;

    typedef logic [NL_OUT_PHASE_BITWIDTH-1:0] phase_t;
    typedef logic [NUM_SPINS_EXP-1:0]         idx_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fill_state_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_SPINS - 1);

endpackage

// File: rtl/spin_phase_deserializer_if.sv
// Serial phase input stream and parallel phase-matrix output towards the adder tree.
// Both sides use valid/ready: a beat or matrix moves on a cycle where valid and ready are both high;
// valid and its payload must then stay stable until that cycle, and ready may depend on valid.
interface spin_phase_deserializer_if;
    import spin_phase_deserializer_pkg::*;

    logic   in_valid;
    logic   in_ready;
    phase_t in_phase;
    logic   in_last;
    logic   out_valid;
    logic   out_ready;
    phase_t phase_matrix [NUM_SPINS-1:0];

    modport master (
        output in_valid, in_phase, in_last, out_ready,
        input  in_ready, out_valid, phase_matrix
    );

    modport slave (
        input  in_valid, in_phase, in_last, out_ready,
        output in_ready, out_valid, phase_matrix
    );

endinterface

// File: rtl/spin_phase_deserializer_frame_counter.sv
// Beat index within the current frame, with wrap on frame end and clear on a framing violation.
module spin_frame_counter
    import spin_phase_deserializer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic accept,
    input  logic in_last,
    output idx_t wr_idx,
    output logic frame_done,
    output logic frame_bad
);

    logic at_last;

    assign at_last    = (wr_idx == LAST_IDX);
    // A beat is well framed exactly when in_last matches the last index.
    assign frame_bad  = accept & (in_last ^ at_last);
    assign frame_done = accept & in_last & at_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx <= '0;
        end else if (accept) begin
            if (at_last || frame_bad) begin
                wr_idx <= '0;
            end else begin
                wr_idx <= wr_idx + idx_t'(1);
            end
        end
    end

endmodule

// File: rtl/spin_phase_deserializer.sv
// Double-buffered serial-to-parallel assembler: fills one frame while the previous matrix
// waits for the adder tree; framing violations drop the partial frame and are counted.
module spin_phase_deserializer
    import spin_phase_deserializer_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ena,
    spin_phase_deserializer_if.slave    bus,
    output logic                        frame_err,
    output logic [ERR_CNT_W-1:0]        err_count,
    output fill_state_t                 fill_state
);

    fill_state_t state;
    fill_state_t next_state;
    idx_t        wr_idx;
    logic        frame_done;
    logic        frame_bad;
    logic        accept;
    logic        pop;
    logic        xfer_live;
    logic        xfer_hold;
    logic        out_valid_q;
    phase_t      fill_buf [NUM_SPINS-1:0];
    phase_t      matrix_q [NUM_SPINS-1:0];

    // Reset gates ready combinationally so acceptance stops the instant reset asserts.
    assign bus.in_ready     = (state == FILL) & ena & reset;
    assign accept           = ena & bus.in_valid & bus.in_ready;
    assign pop              = out_valid_q & bus.out_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.phase_matrix = matrix_q;
    assign fill_state       = state;

    spin_frame_counter u_counter (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept),
        .in_last    (bus.in_last),
        .wr_idx     (wr_idx),
        .frame_done (frame_done),
        .frame_bad  (frame_bad)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        xfer_live  = 1'b0;
        xfer_hold  = 1'b0;
        case (state)
            FILL: begin
                if (frame_done) begin
                    if (!out_valid_q || pop) begin
                        xfer_live = 1'b1;
                    end else begin
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (pop) begin
                    xfer_hold  = 1'b1;
                    next_state = FILL;
                end
            end
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_buf    <= '{default: '0};
            matrix_q    <= '{default: '0};
            out_valid_q <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_err <= frame_bad;
            if (frame_bad && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            if (accept && !frame_bad) begin
                fill_buf[wr_idx] <= bus.in_phase;
            end
            // The final beat is forwarded directly so a free output loads in the same cycle.
            if (xfer_live) begin
                matrix_q           <= fill_buf;
                matrix_q[LAST_IDX] <= bus.in_phase;
                out_valid_q        <= 1'b1;
            end else if (xfer_hold) begin
                matrix_q    <= fill_buf;
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spin_phase_deserializer.md
Name: spin_phase_deserializer

Overview:
- Writer-side front end for the phase-summation adder tree (Adder64to1).
- Accepts a serial stream of NUM_SPINS spin phases over a valid/ready handshake and assembles them into one parallel phase matrix.
- Presents each completed matrix to the adder with valid/ready.
- Double-buffered: a new frame fills while the previous matrix waits to be consumed.

Parameters:
- NUM_SPINS, 64, spins per frame; power of two.
- NUM_SPINS_EXP, 6, log2(NUM_SPINS); width of the beat index.
- NL_OUT_PHASE_BITWIDTH, 8, width of one spin phase.
- ERR_CNT_W, 8, width of the saturating frame-error counter.

Ports:
- clk, in, 1, system clock; all state on the rising edge.
- reset, in, 1, asynchronous active-low reset.
- ena, in, 1, input-side enable; low stalls acceptance.
- in_valid, in, 1, upstream phase beat valid.
- in_ready, out, 1, deserializer can accept a beat.
- in_phase, in, NL_OUT_PHASE_BITWIDTH, phase of spin number wr_idx.
- in_last, in, 1, asserted on the final beat of a frame.
- out_valid, out, 1, phase_matrix holds a complete frame.
- out_ready, in, 1, adder consumes phase_matrix.
- phase_matrix, out, NL_OUT_PHASE_BITWIDTH x NUM_SPINS (unpacked [NUM_SPINS-1:0]), assembled phases; index i = i-th beat of the frame.
- frame_err, out, 1, one-cycle pulse on a framing violation.
- err_count, out, ERR_CNT_W, saturating count of framing violations.

Behaviour:
- Reset (reset=0, asynchronous): in_ready=0, out_valid=0, phase_matrix all zero, frame_err=0, err_count=0, wr_idx=0, fill FSM=FILL, fill buffer zero.
- Handshake:
  - accept = ena & in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid/in_phase/in_last must stay stable until accepted; the block does not check this.
- Fill FSM, state FILL:
  - in_ready = ena.
  - On accept: fill_buf[wr_idx] <= in_phase.
  - If wr_idx < NUM_SPINS-1 and in_last=0: wr_idx++.
  - If wr_idx = NUM_SPINS-1 and in_last=1, frame complete:
    - If out_valid=0 or pop in the same cycle: transfer immediately; phase_matrix <= fill_buf, with the last beat forwarded into entry NUM_SPINS-1. out_valid=1 next cycle. wr_idx wraps to 0 and the FSM stays in FILL.
    - Otherwise go to HOLD; wr_idx wraps to 0.
- Fill FSM, state HOLD:
  - in_ready=0.
  - Transfer on the first cycle with pop=1. In that cycle phase_matrix <= fill_buf, out_valid stays 1, and the FSM returns to FILL.
  - ena has no effect in HOLD.
- Latency:
  - Last beat accepted in cycle t, output free → out_valid=1 and phase_matrix valid in cycle t+1.
  - Back-to-back throughput: one beat per cycle, so one frame per NUM_SPINS cycles while out_ready=1.
- Output side:
  - out_valid clears after a pop with no simultaneous transfer.
  - phase_matrix is held unchanged while out_valid=1 and no pop occurs.
  - The output side is independent of ena.
- Framing errors:
  - Triggers: in_last=1 with wr_idx ≠ NUM_SPINS-1, or in_last=0 with wr_idx = NUM_SPINS-1.
  - On an accepted erroneous beat: discard the partial frame, wr_idx <= 0, frame_err=1 in the next cycle, err_count++ saturating at 2^ERR_CNT_W-1.
  - No transfer occurs and out_valid is unaffected.
- ena=0: in_ready=0 in FILL, wr_idx and fill_buf frozen; a partially filled frame resumes when ena returns.
- Simultaneous last-beat accept and pop with out_valid=1: transfer in the same cycle; out_valid stays 1; no HOLD.
- Reset mid-frame: partial frame lost, all outputs return to reset values immediately. The first beat after reset release is beat 0.

Decomposition:
- common_pkg_SCRIPT holds NUM_SPINS, NUM_SPINS_EXP and NL_OUT_PHASE_BITWIDTH.
- Add to the package: typedef phase_t (logic [NL_OUT_PHASE_BITWIDTH-1:0]) and a fill-state enum {FILL, HOLD}.
- One natural sub-module: spin_frame_counter. It holds the wr_idx counter with wrap/clear, plus the last/index mismatch detect.
- Buffers and the output register stay in the top level.

Test Plan:
- Back-to-back frames: feed beats i → in_phase=i for i=0..63, in_last on beat 63, out_ready=1. Expect out_valid at the cycle after beat 63, phase_matrix[i]=i, and an Adder64to1 sum of 2016. A second frame with phase 2i streams without in_ready dropping.
- Backpressure: hold out_ready=0 after frame 1 and send frame 2 (all 8'h05). Expect in_ready=0 after frame 2's last beat (HOLD) and phase_matrix unchanged. Raising out_ready for 1 cycle pops frame 1 and loads all 8'h05; in_ready returns to 1 the next cycle.
- Early last: in_last=1 on beat 10. Expect frame_err pulse, err_count=1 and out_valid unchanged; the following full 64-beat frame is assembled correctly from index 0.
- Missing last: beat 63 with in_last=0. Expect frame_err and err_count increment; 300 consecutive errors saturate err_count at 255.
- ena stall: drop ena for 5 cycles at beat 30. Expect in_ready=0 and no index advance; after resume, phase_matrix[30..63] correct and out_valid asserts exactly after 64 accepted beats.
- Async reset mid-frame: assert reset at beat 40. Expect out_valid=0, phase_matrix=0 and in_ready=0 immediately; after release, a fresh 64-beat frame completes correctly.
